vector_loader: RTL and testbench

VECTOR_LOADER -- requirements
Module: vector_loader

---
 rtl/vector_loader.sv | 143 ++++++++++++++
 tb/tb_vector_loader.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_loader.sv
// Assembles N streamed Q8.8 samples into one vector for a neuron stage, enforcing s_last framing.
// Optional build macro LOADER_CLAMP_EN clamps each sample to +/-CLAMP_MAX before it is stored.
module vector_loader #(
  parameter int unsigned             WIDTH     = 16,
  parameter int unsigned             N         = 4,
  parameter logic signed [WIDTH-1:0] CLAMP_MAX = 16'sd2048
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [WIDTH-1:0] s_data,
  input  logic                    s_last,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic signed [WIDTH-1:0] m_vec [0:N-1],
  output logic                    frame_err,
  output logic [7:0]              err_cnt
);

  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    HOLD = 2'd1,
    DROP = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic signed [WIDTH-1:0] vec_q [0:N-1];
  logic signed [WIDTH-1:0] vec_d [0:N-1];
  logic                    s_ready_q, s_ready_d;
  logic                    m_valid_q, m_valid_d;
  logic                    err_q, err_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    s_beat;
  logic signed [WIDTH-1:0] sample;

  assign s_beat = s_valid && s_ready_q;

`ifdef LOADER_CLAMP_EN
  // Saturate out-of-range samples symmetrically before storage.
  always_comb begin
    sample = s_data;
    if (s_data > CLAMP_MAX) begin
      sample = CLAMP_MAX;
    end else if (s_data < -CLAMP_MAX) begin
      sample = -CLAMP_MAX;
    end
  end
`else
  assign sample = s_data;
  logic unused_clamp;
  assign unused_clamp = ^CLAMP_MAX;
`endif

  // Next-state, element write and framing-error decode.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    vec_d   = vec_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;

    case (state_q)
      FILL: begin
        if (s_beat) begin
          vec_d[idx_q] = sample;
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            if (s_last) begin
              state_d = HOLD;
            end else begin
              err_d   = 1'b1;
              state_d = DROP;
            end
          end else if (s_last) begin
            err_d = 1'b1;
            idx_d = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      HOLD: begin
        if (m_ready) begin
          state_d = FILL;
          idx_d   = '0;
        end
      end
      DROP: begin
        if (s_beat && s_last) begin
          state_d = FILL;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = FILL;
        idx_d   = '0;
      end
    endcase

    if (err_d && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end

    s_ready_d = (state_d != HOLD);
    m_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= FILL;
      idx_q     <= '0;
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= 8'd0;
      for (int i = 0; i < N; i++) begin
        vec_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      for (int i = 0; i < N; i++) begin
        vec_q[i] <= vec_d[i];
      end
    end
  end

  assign s_ready   = s_ready_q;
  assign m_valid   = m_valid_q;
  assign frame_err = err_q;
  assign err_cnt   = cnt_q;
  assign m_vec     = vec_q;

endmodule

// File: tb/tb_vector_loader.sv
// Self-checking bench for vector_loader: directed framing scenarios plus randomized traffic
// checked against a frame-level queue model.
module tb_vector_loader;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned N     = 4;

  logic                    clk     = 1'b0;
  logic                    rst_n   = 1'b0;
  logic                    s_valid = 1'b0;
  logic                    s_last  = 1'b0;
  logic                    m_ready = 1'b0;
  logic signed [WIDTH-1:0] s_data  = '0;
  logic                    s_ready;
  logic                    m_valid;
  logic                    frame_err;
  logic [7:0]              err_cnt;
  logic signed [WIDTH-1:0] m_vec [0:N-1];
  logic [N*WIDTH-1:0]      vec_flat;

  int total = 0;
  int bad   = 0;

  // Reference model: samples of the frame in progress, pending vector, drop mode, error count.
  logic signed [WIDTH-1:0] cur[$];
  logic [N*WIDTH-1:0]      exp_vec;
  bit                      exp_hold;
  bit                      exp_drop;
  bit                      exp_err;
  int                      exp_cnt;

  vector_loader #(.WIDTH(WIDTH), .N(N), .CLAMP_MAX(16'sd2048)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_vec(m_vec),
    .frame_err(frame_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) vec_flat[i*WIDTH +: WIDTH] = m_vec[i];
  end

  function automatic logic signed [WIDTH-1:0] clampf(input logic signed [WIDTH-1:0] x);
`ifdef LOADER_CLAMP_EN
    if (x > 16'sd2048) return 16'sd2048;
    if (x < -16'sd2048) return -16'sd2048;
`endif
    return x;
  endfunction

  // Apply one cycle of inputs, advance the frame model for that edge, settle 1 time unit past it.
  task automatic cycle(input bit sv, input logic signed [WIDTH-1:0] sd, input bit sl, input bit mr);
    s_valid = sv; s_data = sd; s_last = sl; m_ready = mr;
    exp_err = 1'b0;
    if (exp_hold) begin
      if (mr) exp_hold = 1'b0;
    end else if (sv) begin
      if (exp_drop) begin
        if (sl) exp_drop = 1'b0;
      end else begin
        cur.push_back(clampf(sd));
        if (cur.size() == N) begin
          if (sl) begin
            for (int i = 0; i < N; i++) exp_vec[i*WIDTH +: WIDTH] = cur[i];
            exp_hold = 1'b1;
          end else begin
            exp_err  = 1'b1;
            exp_drop = 1'b1;
          end
          cur.delete();
        end else if (sl) begin
          exp_err = 1'b1;
          cur.delete();
        end
      end
    end
    if (exp_err && exp_cnt < 255) exp_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cur.delete(); exp_hold = 1'b0; exp_drop = 1'b0; exp_err = 1'b0; exp_cnt = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({m_valid, s_ready, frame_err, err_cnt} !== {1'b0, 1'b1, 1'b0, 8'd0}) begin
      bad++; $display("FAIL reset_status: got %b want %b", {m_valid, s_ready, frame_err, err_cnt}, 11'b01000000000);
    end
    total++;
    if (vec_flat !== '0) begin
      bad++; $display("FAIL reset_vec: got %h want 0", vec_flat);
    end
  endtask

  task automatic test_basic();
    logic [N*WIDTH-1:0] want;
    want = {16'sd2586, -16'sd77, 16'sd358, -16'sd384};
    do_reset();
    cycle(1, -16'sd384, 0, 1);
    cycle(1, 16'sd358, 0, 1);
    cycle(1, -16'sd77, 0, 1);
    total++;
    if (m_valid !== 1'b0) begin
      bad++; $display("FAIL basic_early_valid: got %b want 0", m_valid);
    end
    cycle(1, 16'sd2586, 1, 1);
    total++;
    if ({m_valid, s_ready} !== 2'b10) begin
      bad++; $display("FAIL basic_handshake: got %b want 10", {m_valid, s_ready});
    end
    total++;
    if (vec_flat !== want) begin
      bad++; $display("FAIL basic_vec: got %h want %h", vec_flat, want);
    end
    cycle(0, 16'sd0, 0, 1);
    total++;
    if ({m_valid, s_ready, frame_err} !== 3'b010) begin
      bad++; $display("FAIL basic_release: got %b want 010", {m_valid, s_ready, frame_err});
    end
  endtask

  task automatic test_hold();
    logic [N*WIDTH-1:0] want;
    want = {16'sd2586, -16'sd77, 16'sd358, -16'sd384};
    do_reset();
    cycle(1, -16'sd384, 0, 0);
    cycle(1, 16'sd358, 0, 0);
    cycle(1, -16'sd77, 0, 0);
    cycle(1, 16'sd2586, 1, 0);
    for (int k = 0; k < 5; k++) begin
      total++;
      if ({m_valid, s_ready} !== 2'b10 || vec_flat !== want) begin
        bad++; $display("FAIL hold_stable[%0d]: got %b/%h want 10/%h", k, {m_valid, s_ready}, vec_flat, want);
      end
      cycle(1, 16'sd999, (k == 4), 0);
    end
    cycle(0, 16'sd0, 0, 1);
    total++;
    if ({m_valid, s_ready} !== 2'b01) begin
      bad++; $display("FAIL hold_release: got %b want 01", {m_valid, s_ready});
    end
    want = {16'sd40, 16'sd30, 16'sd20, 16'sd10};
    cycle(1, 16'sd10, 0, 0);
    cycle(1, 16'sd20, 0, 0);
    cycle(1, 16'sd30, 0, 0);
    cycle(1, 16'sd40, 1, 0);
    total++;
    if (m_valid !== 1'b1 || vec_flat !== want || err_cnt !== 8'd0) begin
      bad++; $display("FAIL hold_next_vec: got %b/%h/%0d want 1/%h/0", m_valid, vec_flat, err_cnt, want);
    end
  endtask

  task automatic test_short_frame();
    logic [N*WIDTH-1:0] want;
    want = {16'sd4, 16'sd3, 16'sd2, 16'sd1};
    do_reset();
    cycle(1, 16'sd11, 0, 0);
    cycle(1, 16'sd22, 1, 0);
    total++;
    if ({frame_err, err_cnt, m_valid} !== {1'b1, 8'd1, 1'b0}) begin
      bad++; $display("FAIL short_err: got %b want 1000000010", {frame_err, err_cnt, m_valid});
    end
    cycle(0, 16'sd0, 0, 0);
    total++;
    if (frame_err !== 1'b0) begin
      bad++; $display("FAIL short_pulse_width: got %b want 0", frame_err);
    end
    cycle(1, 16'sd1, 0, 0);
    cycle(1, 16'sd2, 0, 0);
    cycle(1, 16'sd3, 0, 0);
    cycle(1, 16'sd4, 1, 0);
    total++;
    if (m_valid !== 1'b1 || vec_flat !== want || err_cnt !== 8'd1) begin
      bad++; $display("FAIL short_recover: got %b/%h/%0d want 1/%h/1", m_valid, vec_flat, err_cnt, want);
    end
  endtask

  task automatic test_long_frame();
    logic [N*WIDTH-1:0] want;
    want = {16'sd10, 16'sd9, 16'sd8, 16'sd7};
    do_reset();
    for (int k = 0; k < 4; k++) cycle(1, 16'(100 + k), 0, 0);
    total++;
    if ({frame_err, err_cnt, m_valid} !== {1'b1, 8'd1, 1'b0}) begin
      bad++; $display("FAIL long_err: got %b want 1000000010", {frame_err, err_cnt, m_valid});
    end
    cycle(1, 16'sd104, 0, 0);
    cycle(1, 16'sd105, 1, 0);
    total++;
    if ({frame_err, err_cnt, m_valid, s_ready} !== {1'b0, 8'd1, 1'b0, 1'b1}) begin
      bad++; $display("FAIL long_drop: got %b want 00000000101", {frame_err, err_cnt, m_valid, s_ready});
    end
    for (int k = 0; k < 4; k++) cycle(1, 16'(7 + k), (k == 3), 0);
    total++;
    if (m_valid !== 1'b1 || vec_flat !== want || err_cnt !== 8'd1) begin
      bad++; $display("FAIL long_recover: got %b/%h/%0d want 1/%h/1", m_valid, vec_flat, err_cnt, want);
    end
  endtask

  task automatic test_saturate_and_reset();
    logic [N*WIDTH-1:0] want;
    want = {16'sd8, 16'sd7, 16'sd6, 16'sd5};
    do_reset();
    for (int k = 0; k < 260; k++) begin
      cycle(1, 16'sd5, 1, 0);
      total++;
      if ({frame_err, err_cnt} !== {exp_err, 8'(exp_cnt)}) begin
        bad++; $display("FAIL sat_step[%0d]: got %b/%0d want %b/%0d", k, frame_err, err_cnt, exp_err, exp_cnt);
      end
    end
    cycle(0, 16'sd0, 0, 0);
    total++;
    if (err_cnt !== 8'd255) begin
      bad++; $display("FAIL sat_final: got %0d want 255", err_cnt);
    end
    cycle(1, 16'sd1, 0, 0);
    cycle(1, 16'sd2, 0, 0);
    do_reset();
    total++;
    if ({err_cnt, m_valid, frame_err, s_ready} !== {8'd0, 1'b0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL midfill_reset: got %b want 00000000001", {err_cnt, m_valid, frame_err, s_ready});
    end
    for (int k = 0; k < 4; k++) cycle(1, 16'(5 + k), (k == 3), 0);
    total++;
    if (m_valid !== 1'b1 || vec_flat !== want || {frame_err, err_cnt} !== 9'd0) begin
      bad++; $display("FAIL midfill_restart: got %b/%h/%0d want 1/%h/0", m_valid, vec_flat, err_cnt, want);
    end
  endtask

  task automatic test_clamp();
    logic [N*WIDTH-1:0] want;
`ifdef LOADER_CLAMP_EN
    want = {-16'sd77, 16'sd2048, -16'sd2048, 16'sd2048};
`else
    want = {-16'sd77, 16'sd2048, -16'sd32768, 16'sd2586};
`endif
    do_reset();
    cycle(1, 16'sd2586, 0, 0);
    cycle(1, -16'sd32768, 0, 0);
    cycle(1, 16'sd2048, 0, 0);
    cycle(1, -16'sd77, 1, 0);
    total++;
    if (m_valid !== 1'b1 || vec_flat !== want) begin
      bad++; $display("FAIL clamp_vec: got %b/%h want 1/%h", m_valid, vec_flat, want);
    end
    cycle(0, 16'sd0, 0, 1);
  endtask

  task automatic test_random();
    int flen, fpos;
    bit sv, sl, mr;
    int lens [7] = '{4, 4, 4, 2, 6, 1, 5};
    do_reset();
    flen = lens[$urandom_range(0, 6)];
    fpos = 0;
    for (int k = 0; k < 3000; k++) begin
      sv = ($urandom_range(0, 3) != 0);
      mr = ($urandom_range(0, 2) == 0);
      sl = (fpos == flen - 1);
      if (sv && !exp_hold) begin
        fpos++;
        if (sl) begin
          fpos = 0;
          flen = lens[$urandom_range(0, 6)];
        end
      end
      cycle(sv, 16'($urandom), sl, mr);
      total++;
      if ({m_valid, s_ready, frame_err, err_cnt} !== {exp_hold, !exp_hold, exp_err, 8'(exp_cnt)}) begin
        bad++; $display("FAIL rand_status[%0d]: got %b want %b", k, {m_valid, s_ready, frame_err, err_cnt},
                        {exp_hold, !exp_hold, exp_err, 8'(exp_cnt)});
      end
      if (exp_hold) begin
        total++;
        if (vec_flat !== exp_vec) begin
          bad++; $display("FAIL rand_vec[%0d]: got %h want %h", k, vec_flat, exp_vec);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_short_frame();
    test_long_frame();
    test_saturate_and_reset();
    test_clamp();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
